pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage pipeline. Each cycle it decides which pipeline latches hold (stall) and which take a bubble (nop). Its causes are load-use hazards, taken branches/jumps resolved in execute, instruction- and data-memory busy handshakes, and HALT drain. It drives the fetch/decode, decode/execute and execute/memory latch controls, the PC write enable, and a saturating stall-cycle counter.

---
 rtl/pipeline_ctrl_pkg.sv | 23 ++
 rtl/load_use_detect.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding, register-id width and the bubble constants used by the datapath.
package pipeline_ctrl_pkg;

  localparam logic [1:0] ST_RUN         = 2'd0;
  localparam logic [1:0] ST_SQUASH_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN       = 2'd2;
  localparam logic [1:0] ST_HALTED      = 2'd3;

  localparam int REG_ID_W = 3;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] NOP_PC    = 16'hFFFF;

  // A source operand conflicts with the load in execute only when the
  // decode instruction really reads it and the register ids agree.
  function automatic logic srcHazard(input logic [REG_ID_W-1:0] src,
                                     input logic                used,
                                     input logic [REG_ID_W-1:0] dst);
    return used && (src == dst);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Detects a load in execute whose destination feeds the instruction in decode.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ID_W-1:0] rs_i,
  input  logic [REG_ID_W-1:0] rt_i,
  input  logic                rs_used_i,
  input  logic                rt_used_i,
  input  logic [REG_ID_W-1:0] rd_i,
  input  logic                mem_read_i,
  output logic                load_use_o
);

  // Either gated source matching the load destination forces a one-cycle stall.
  always_comb begin
    load_use_o = mem_read_i &&
                 (srcHazard(rs_i, rs_used_i, rd_i) || srcHazard(rt_i, rt_used_i, rd_i));
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/bubble controller for the 5-stage pipeline: prioritises data
// memory waits, branch redirects, load-use hazards, fetch misses and HALT drain.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W  = 16,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ID_W-1:0]    rs_d,
  input  logic [REG_ID_W-1:0]    rt_d,
  input  logic                   rs_used_d,
  input  logic                   rt_used_d,
  input  logic                   halt_d,
  input  logic [REG_ID_W-1:0]    rd_x,
  input  logic                   mem_read_x,
  input  logic                   br_taken_x,
  input  logic                   imem_busy,
  input  logic                   dmem_busy,
  output logic                   pc_en,
  output logic                   stall_fd,
  output logic                   nop_fd,
  output logic                   stall_de,
  output logic                   nop_de,
  output logic                   stall_em,
  output logic                   nop_mw,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  logic [1:0]             state_q, state_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic                   loadUse;
  logic pcEnC, stallFdC, nopFdC, stallDeC, nopDeC, stallEmC, nopMwC, haltedC;

  load_use_detect u_load_use_detect (
    .rs_i       (rs_d),
    .rt_i       (rt_d),
    .rs_used_i  (rs_used_d),
    .rt_used_i  (rt_used_d),
    .rd_i       (rd_x),
    .mem_read_i (mem_read_x),
    .load_use_o (loadUse)
  );

  // Priority mux and next-state logic; a dmem wait freezes everything,
  // including the FSM and the drain countdown.
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    pcEnC    = 1'b1;
    stallFdC = 1'b0;
    nopFdC   = 1'b0;
    stallDeC = 1'b0;
    nopDeC   = 1'b0;
    stallEmC = 1'b0;
    nopMwC   = 1'b0;
    haltedC  = 1'b0;
    if (state_q == ST_HALTED) begin
      haltedC  = 1'b1;
      pcEnC    = 1'b0;
      stallFdC = 1'b1;
      stallDeC = 1'b1;
      stallEmC = 1'b1;
    end else if (dmem_busy) begin
      pcEnC    = 1'b0;
      stallFdC = 1'b1;
      stallDeC = 1'b1;
      stallEmC = 1'b1;
      nopMwC   = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (br_taken_x) begin
            nopFdC = 1'b1;
            nopDeC = 1'b1;
            if (imem_busy) state_d = ST_SQUASH_WAIT;
          end else if (loadUse) begin
            pcEnC    = 1'b0;
            stallFdC = 1'b1;
            nopDeC   = 1'b1;
          end else if (imem_busy) begin
            pcEnC  = 1'b0;
            nopFdC = 1'b1;
          end else if (halt_d) begin
            state_d = ST_DRAIN;
            drain_d = DW'(DRAIN_CYCLES);
          end
        end
        ST_SQUASH_WAIT: begin
          pcEnC  = 1'b0;
          nopFdC = 1'b1;
          if (!imem_busy) state_d = ST_RUN;
        end
        ST_DRAIN: begin
          pcEnC  = 1'b0;
          nopFdC = 1'b1;
          if (drain_q <= DW'(1)) begin
            drain_d = '0;
            state_d = ST_HALTED;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating count of lost fetch cycles while running or draining.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == ST_RUN || state_q == ST_DRAIN) && !pcEnC && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  // State, drain counter and stall counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are held at zero while reset is asserted; stall beats nop per latch.
  always_comb begin
    pc_en        = ~rst & pcEnC;
    stall_fd     = ~rst & stallFdC;
    nop_fd       = ~rst & nopFdC & ~stallFdC;
    stall_de     = ~rst & stallDeC;
    nop_de       = ~rst & nopDeC & ~stallDeC;
    stall_em     = ~rst & stallEmC;
    nop_mw       = ~rst & nopMwC;
    halted       = ~rst & haltedC;
    stall_cycles = rst ? '0 : cnt_q;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  rs_d, rt_d, rd_x;
  logic        rs_used_d, rt_used_d, halt_d, mem_read_x, br_taken_x, imem_busy, dmem_busy;
  logic        pc_en, stall_fd, nop_fd, stall_de, nop_de, stall_em, nop_mw, halted;
  logic [15:0] stall_cycles;
  logic [7:0]  ctl;

  int testsRun    = 0;
  int testsFailed = 0;

  // ctl = {pc_en, stall_fd, nop_fd, stall_de, nop_de, stall_em, nop_mw, halted}
  localparam logic [7:0] C_ZERO   = 8'b0000_0000;
  localparam logic [7:0] C_IDLE   = 8'b1000_0000;
  localparam logic [7:0] C_LU     = 8'b0100_1000;
  localparam logic [7:0] C_BR     = 8'b1010_1000;
  localparam logic [7:0] C_FETCH  = 8'b0010_0000;
  localparam logic [7:0] C_FREEZE = 8'b0101_0110;
  localparam logic [7:0] C_HALTED = 8'b0101_0101;

  pipeline_hazard_ctrl #(.STALL_CNT_W(16), .DRAIN_CYCLES(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .rs_used_d    (rs_used_d),
    .rt_used_d    (rt_used_d),
    .halt_d       (halt_d),
    .rd_x         (rd_x),
    .mem_read_x   (mem_read_x),
    .br_taken_x   (br_taken_x),
    .imem_busy    (imem_busy),
    .dmem_busy    (dmem_busy),
    .pc_en        (pc_en),
    .stall_fd     (stall_fd),
    .nop_fd       (nop_fd),
    .stall_de     (stall_de),
    .nop_de       (nop_de),
    .stall_em     (stall_em),
    .nop_mw       (nop_mw),
    .halted       (halted),
    .stall_cycles (stall_cycles)
  );

  assign ctl = {pc_en, stall_fd, nop_fd, stall_de, nop_de, stall_em, nop_mw, halted};

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load-use stimulus uses rd_x=3 against rs_d=3 with rs_used_d.
  task automatic applyStimulus(input logic dmem, input logic br, input logic imem,
                               input logic halt, input logic loadUse);
    dmem_busy  = dmem;
    br_taken_x = br;
    imem_busy  = imem;
    halt_d     = halt;
    mem_read_x = loadUse;
    rd_x       = 3'd3;
    rs_d       = 3'd3;
    rs_used_d  = loadUse;
    rt_d       = 3'd5;
    rt_used_d  = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ctl_in_reset_t0", 32'(ctl), 32'(C_ZERO));
    tick();
    checkOutput("ctl_in_reset", 32'(ctl), 32'(C_ZERO));
    checkOutput("cnt_after_reset", 32'(stall_cycles), 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("idle_after_reset", 32'(ctl), 32'(C_IDLE));

    // Load-use: one stall cycle, then free.
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("loaduse_rs", 32'(ctl), 32'(C_LU));
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("loaduse_gone", 32'(ctl), 32'(C_IDLE));
    checkOutput("cnt_loaduse", 32'(stall_cycles), 32'd1);
    mem_read_x = 1'b1; rd_x = 3'd3; rs_d = 3'd3; rs_used_d = 1'b0;
    rt_d = 3'd5; rt_used_d = 1'b1;
    #1;
    checkOutput("loaduse_unused_rs", 32'(ctl), 32'(C_IDLE));
    rt_d = 3'd3;
    #1;
    checkOutput("loaduse_rt", 32'(ctl), 32'(C_LU));
    rt_used_d = 1'b0;
    #1;
    checkOutput("loaduse_unused_rt", 32'(ctl), 32'(C_IDLE));
    applyStimulus(0, 0, 0, 0, 0);
    tick();

    // Taken branch with a fetch miss lasting three cycles.
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("br_miss_c0", 32'(ctl), 32'(C_BR));
    tick();
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("br_miss_c1", 32'(ctl), 32'(C_FETCH));
    tick();
    checkOutput("br_miss_c2", 32'(ctl), 32'(C_FETCH));
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("br_miss_c3_fall", 32'(ctl), 32'(C_FETCH));
    tick();
    checkOutput("br_miss_back_run", 32'(ctl), 32'(C_IDLE));
    checkOutput("cnt_squash_not_counted", 32'(stall_cycles), 32'd1);

    // dmem wait overrides branch and load-use; branch handled when it drops.
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("simul_freeze", 32'(ctl), 32'(C_FREEZE));
    tick();
    applyStimulus(0, 1, 0, 0, 1);
    checkOutput("simul_branch_after", 32'(ctl), 32'(C_BR));
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("simul_idle", 32'(ctl), 32'(C_IDLE));
    checkOutput("cnt_freeze", 32'(stall_cycles), 32'd2);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("imiss_alone", 32'(ctl), 32'(C_FETCH));
    tick();
    checkOutput("cnt_imiss", 32'(stall_cycles), 32'd3);

    // HALT drain with one dmem wait in the middle: halted after five edges.
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("halt_issue", 32'(ctl), 32'(C_IDLE));
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("drain_e1", 32'(ctl), 32'(C_FETCH));
    tick();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("drain_dmem", 32'(ctl), 32'(C_FREEZE));
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("drain_e3", 32'(ctl), 32'(C_FETCH));
    tick();
    checkOutput("drain_e4_not_halted", 32'(ctl), 32'(C_FETCH));
    tick();
    checkOutput("halted_e5", 32'(ctl), 32'(C_HALTED));
    checkOutput("cnt_drain", 32'(stall_cycles), 32'd7);
    applyStimulus(1, 1, 1, 1, 1);
    checkOutput("halted_sticky", 32'(ctl), 32'(C_HALTED));
    tick();
    checkOutput("cnt_halted_frozen", 32'(stall_cycles), 32'd7);

    // Reset from HALTED.
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_halted_ctl", 32'(ctl), 32'(C_ZERO));
    tick();
    checkOutput("rst_halted_cnt", 32'(stall_cycles), 32'd0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_halted_run", 32'(ctl), 32'(C_IDLE));

    // HALT squashed by a simultaneous branch: no drain.
    applyStimulus(0, 1, 0, 1, 0);
    checkOutput("halt_br_branch", 32'(ctl), 32'(C_BR));
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("halt_br_no_drain", 32'(ctl), 32'(C_IDLE));
    tick();
    checkOutput("halt_br_still_run", 32'(ctl), 32'(C_IDLE));
    checkOutput("halt_br_cnt", 32'(stall_cycles), 32'd0);

    // Reset from SQUASH_WAIT leaves no residual squash.
    applyStimulus(0, 1, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("squash_before_rst", 32'(ctl), 32'(C_FETCH));
    rst = 1'b1;
    #1;
    checkOutput("rst_squash_ctl", 32'(ctl), 32'(C_ZERO));
    tick();
    rst = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_squash_run", 32'(ctl), 32'(C_IDLE));
    checkOutput("rst_squash_cnt", 32'(stall_cycles), 32'd0);

    // Saturation of the 16-bit stall counter via a long fetch miss.
    applyStimulus(0, 0, 1, 0, 0);
    repeat (65534) tick();
    checkOutput("cnt_pre_sat", 32'(stall_cycles), 32'h0000_FFFE);
    tick();
    checkOutput("cnt_sat", 32'(stall_cycles), 32'h0000_FFFF);
    repeat (5) tick();
    checkOutput("cnt_sat_hold", 32'(stall_cycles), 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
